// File: rtl/sram_arbiter.sv
// Two-port round-robin SRAM array controller: masked single-word writes and
// 1-4 beat incrementing read bursts. Optional grant counters under SRAM_ARB_PERF_EN.
module sram_arbiter #(
  parameter int unsigned ROWS       = 64,
  parameter int unsigned COLS       = 64,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned NUM_COL_GROUPS = COLS / DATA_WIDTH,
  localparam int unsigned ROW_W          = $clog2(ROWS),
  localparam int unsigned COL_W          = $clog2(NUM_COL_GROUPS),
  localparam int unsigned ADDR_W         = ROW_W + COL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [ADDR_W-1:0]     p0_req_addr,
  input  logic [1:0]            p0_req_len,
  input  logic [DATA_WIDTH-1:0] p0_req_wmask,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_wr_ack,
  output logic                  p0_rsp_valid,
  input  logic                  p0_rsp_ready,
  output logic [DATA_WIDTH-1:0] p0_rsp_data,
  output logic                  p0_rsp_last,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [ADDR_W-1:0]     p1_req_addr,
  input  logic [1:0]            p1_req_len,
  input  logic [DATA_WIDTH-1:0] p1_req_wmask,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  output logic                  p1_wr_ack,
  output logic                  p1_rsp_valid,
  input  logic                  p1_rsp_ready,
  output logic [DATA_WIDTH-1:0] p1_rsp_data,
  output logic                  p1_rsp_last,
  output logic [ROW_W-1:0]      arr_row_select,
  output logic [COL_W-1:0]      arr_col_select,
  output logic [DATA_WIDTH-1:0] arr_write_enable,
  output logic [DATA_WIDTH-1:0] arr_data_in,
  input  logic [DATA_WIDTH-1:0] arr_data_out
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [15:0]           p0_grant_cnt,
  output logic [15:0]           p1_grant_cnt
`endif
);

  localparam int unsigned NUM_WORDS = ROWS * NUM_COL_GROUPS;

  typedef enum logic {ST_IDLE, ST_READ} state_e;

  state_e                          state_q, state_d;
  logic                            last_grant_q, last_grant_d;
  logic                            burst_port_q, burst_port_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [2:0]                      beats_q, beats_d;
  logic [1:0]                      rsp_valid_q, rsp_valid_d;
  logic [1:0]                      rsp_last_q, rsp_last_d;
  logic [1:0]                      wr_ack_q, wr_ack_d;
  logic [1:0][DATA_WIDTH-1:0]      rsp_data_q, rsp_data_d;

  logic [1:0]                      req_valid, req_we, rsp_ready, eligible;
  logic [1:0][ADDR_W-1:0]          req_addr;
  logic [1:0][1:0]                 req_len;
  logic [1:0][DATA_WIDTH-1:0]      req_wmask, req_wdata;
  logic                            grant_valid_c, grant_port_c;
  logic [1:0]                      req_ready_c;
  logic [ADDR_W-1:0]               arr_addr_c;
  logic [DATA_WIDTH-1:0]           arr_we_c;

  assign req_valid = {p1_req_valid, p0_req_valid};
  assign req_we    = {p1_req_we, p0_req_we};
  assign req_addr  = {p1_req_addr, p0_req_addr};
  assign req_len   = {p1_req_len, p0_req_len};
  assign req_wmask = {p1_req_wmask, p0_req_wmask};
  assign req_wdata = {p1_req_wdata, p0_req_wdata};
  assign rsp_ready = {p1_rsp_ready, p0_rsp_ready};

  // Reads wait until neither port holds an unconsumed beat; writes never wait.
  always_comb begin
    eligible      = req_valid & (req_we | {2{rsp_valid_q == 2'b00}});
    grant_valid_c = 1'b0;
    grant_port_c  = 1'b0;
    req_ready_c   = 2'b00;
    if (state_q == ST_IDLE && !rst) begin
      if (eligible == 2'b11) begin
        grant_valid_c = 1'b1;
        grant_port_c  = ~last_grant_q;
      end else if (eligible[0]) begin
        grant_valid_c = 1'b1;
      end else if (eligible[1]) begin
        grant_valid_c = 1'b1;
        grant_port_c  = 1'b1;
      end
    end
    req_ready_c[grant_port_c] = grant_valid_c;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_port_d = burst_port_q;
    addr_d       = addr_q;
    beats_d      = beats_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_last_d   = rsp_last_q;
    rsp_data_d   = rsp_data_q;
    wr_ack_d     = 2'b00;
    arr_addr_c   = req_addr[grant_port_c];
    arr_we_c     = '0;

    for (int p = 0; p < 2; p++) begin
      if (rsp_valid_q[p] && rsp_ready[p]) begin
        rsp_valid_d[p] = 1'b0;
        rsp_last_d[p]  = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_valid_c) begin
          last_grant_d = grant_port_c;
          if (req_we[grant_port_c]) begin
            arr_we_c               = req_wmask[grant_port_c];
            wr_ack_d[grant_port_c] = 1'b1;
          end else begin
            burst_port_d = grant_port_c;
            addr_d       = req_addr[grant_port_c];
            beats_d      = 3'(req_len[grant_port_c]) + 3'd1;
            state_d      = ST_READ;
          end
        end
      end
      ST_READ: begin
        arr_addr_c = addr_q;
        // Load a beat whenever the port's output slot is free or being drained.
        if (!rsp_valid_q[burst_port_q] || rsp_ready[burst_port_q]) begin
          rsp_valid_d[burst_port_q] = 1'b1;
          rsp_data_d[burst_port_q]  = arr_data_out;
          rsp_last_d[burst_port_q]  = (beats_q == 3'd1);
          addr_d  = (addr_q == ADDR_W'(NUM_WORDS - 1)) ? '0 : addr_q + ADDR_W'(1);
          beats_d = beats_q - 3'd1;
          if (beats_q == 3'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      burst_port_q <= 1'b0;
      addr_q       <= '0;
      beats_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_last_q   <= '0;
      wr_ack_q     <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_port_q <= burst_port_d;
      addr_q       <= addr_d;
      beats_q      <= beats_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_last_q   <= rsp_last_d;
      wr_ack_q     <= wr_ack_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign p0_req_ready     = req_ready_c[0];
  assign p1_req_ready     = req_ready_c[1];
  assign p0_wr_ack        = wr_ack_q[0];
  assign p1_wr_ack        = wr_ack_q[1];
  assign p0_rsp_valid     = rsp_valid_q[0];
  assign p1_rsp_valid     = rsp_valid_q[1];
  assign p0_rsp_data      = rsp_data_q[0];
  assign p1_rsp_data      = rsp_data_q[1];
  assign p0_rsp_last      = rsp_last_q[0];
  assign p1_rsp_last      = rsp_last_q[1];
  assign arr_row_select   = arr_addr_c[ADDR_W-1 -: ROW_W];
  assign arr_col_select   = arr_addr_c[COL_W-1:0];
  assign arr_write_enable = arr_we_c;
  assign arr_data_in      = req_wdata[grant_port_c];

`ifdef SRAM_ARB_PERF_EN
  logic [1:0][15:0] grant_cnt_q;

  // Saturating per-port count of accepted requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_q <= '0;
    end else if (grant_valid_c && grant_cnt_q[grant_port_c] != 16'hFFFF) begin
      grant_cnt_q[grant_port_c] <= grant_cnt_q[grant_port_c] + 16'd1;
    end
  end

  assign p0_grant_cnt = grant_cnt_q[0];
  assign p1_grant_cnt = grant_cnt_q[1];
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM array, transaction-level reference
// memory/scoreboard, directed scenarios followed by randomized two-port traffic.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       p_valid, p_we, rsp_ready;
  logic [1:0][8:0]  p_addr;
  logic [1:0][1:0]  p_len;
  logic [1:0][7:0]  p_mask, p_wdata;

  logic       p0_req_ready, p1_req_ready, p0_wr_ack, p1_wr_ack;
  logic       p0_rsp_valid, p1_rsp_valid, p0_rsp_last, p1_rsp_last;
  logic [7:0] p0_rsp_data, p1_rsp_data;
  logic [5:0] arr_row_select;
  logic [2:0] arr_col_select;
  logic [7:0] arr_write_enable, arr_data_in, arr_data_out;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p_valid[0]), .p0_req_ready(p0_req_ready), .p0_req_we(p_we[0]),
    .p0_req_addr(p_addr[0]), .p0_req_len(p_len[0]), .p0_req_wmask(p_mask[0]),
    .p0_req_wdata(p_wdata[0]), .p0_wr_ack(p0_wr_ack), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_ready(rsp_ready[0]), .p0_rsp_data(p0_rsp_data), .p0_rsp_last(p0_rsp_last),
    .p1_req_valid(p_valid[1]), .p1_req_ready(p1_req_ready), .p1_req_we(p_we[1]),
    .p1_req_addr(p_addr[1]), .p1_req_len(p_len[1]), .p1_req_wmask(p_mask[1]),
    .p1_req_wdata(p_wdata[1]), .p1_wr_ack(p1_wr_ack), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_ready(rsp_ready[1]), .p1_rsp_data(p1_rsp_data), .p1_rsp_last(p1_rsp_last),
    .arr_row_select(arr_row_select), .arr_col_select(arr_col_select),
    .arr_write_enable(arr_write_enable), .arr_data_in(arr_data_in),
    .arr_data_out(arr_data_out)
  );

  // Cell array: combinational read, per-bit write at the clock edge.
  logic [7:0] mem [512];
  logic       mem_init = 1'b0;
  logic [8:0] arr_idx;
  assign arr_idx      = {arr_row_select, arr_col_select};
  assign arr_data_out = mem[arr_idx];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
      mem_init <= 1'b1;
    end else if (arr_write_enable != 8'h00) begin
      mem[arr_idx] <= (mem[arr_idx] & ~arr_write_enable) | (arr_data_in & arr_write_enable);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: word memory updated at write accept, expected beats queued at read accept.
  logic [7:0] ref_mem [512];
  logic       ref_init = 1'b0;
  logic [8:0] q0[$], q1[$];
  logic [1:0] exp_ack;
  logic       last_grant_m;
  int         ack_cnt [2] = '{0, 0};

  always @(negedge clk) begin
    logic       g, idle_rsp;
    logic [1:0] rdy;
    logic [8:0] a, e;
    if (!ref_init) begin
      for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
      ref_init = 1'b1;
    end
    if (rst) begin
      q0.delete();
      q1.delete();
      exp_ack      = 2'b00;
      last_grant_m = 1'b1;
    end else begin
      check_eq("p0_wr_ack", p0_wr_ack, exp_ack[0]);
      check_eq("p1_wr_ack", p1_wr_ack, exp_ack[1]);
      if (p0_wr_ack) ack_cnt[0]++;
      if (p1_wr_ack) ack_cnt[1]++;
      exp_ack  = 2'b00;
      rdy      = {p1_req_ready, p0_req_ready};
      idle_rsp = (q0.size() == 0) && (q1.size() == 0);
      if (rdy == 2'b11) begin
        check_eq("single_grant", rdy, 2'b01);
      end else if (rdy != 2'b00) begin
        g = rdy[1];
        check_eq("ready_needs_valid", p_valid[g], 1'b1);
        if (p_valid[g]) begin
          if (!p_we[g]) check_eq("read_eligible", idle_rsp, 1'b1);
          if (p_valid[!g] && (p_we[!g] || idle_rsp))
            check_eq("rr_grant", g, !last_grant_m);
          last_grant_m = g;
          if (p_we[g]) begin
            a = p_addr[g];
            ref_mem[a] = (ref_mem[a] & ~p_mask[g]) | (p_wdata[g] & p_mask[g]);
            exp_ack[g] = 1'b1;
          end else begin
            for (int i = 0; i <= int'(p_len[g]); i++) begin
              a = 9'((int'(p_addr[g]) + i) % 512);
              e = {(i == int'(p_len[g])), ref_mem[a]};
              if (g) q1.push_back(e); else q0.push_back(e);
            end
          end
        end
      end
      if (p0_rsp_valid && rsp_ready[0]) begin
        if (q0.size() == 0) check_eq("p0_rsp_unexpected", 1, 0);
        else begin
          e = q0.pop_front();
          check_eq("p0_rsp_data", p0_rsp_data, e[7:0]);
          check_eq("p0_rsp_last", p0_rsp_last, e[8]);
        end
      end
      if (p1_rsp_valid && rsp_ready[1]) begin
        if (q1.size() == 0) check_eq("p1_rsp_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          check_eq("p1_rsp_data", p1_rsp_data, e[7:0]);
          check_eq("p1_rsp_last", p1_rsp_last, e[8]);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  function automatic logic port_ready(input int p);
    return (p == 0) ? p0_req_ready : p1_req_ready;
  endfunction

  // Present one request (caller is just past a rising edge); returns just past
  // the edge that follows the accepting cycle, with valid dropped.
  task automatic send(input int p, input logic we, input logic [8:0] a,
                      input logic [1:0] l, input logic [7:0] m, input logic [7:0] d);
    int n = 0;
    p_we[p] = we; p_addr[p] = a; p_len[p] = l; p_mask[p] = m; p_wdata[p] = d;
    p_valid[p] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!port_ready(p) && n < 200);
    if (!port_ready(p)) check_eq("send_timeout", 0, 1);
    sync();
    p_valid[p] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] burst [4];
    logic [1:0] acc;
    int         base0, base1;
    rst = 1'b1; p_valid = '0; p_we = '0; p_addr = '0; p_len = '0;
    p_mask = '0; p_wdata = '0; rsp_ready = 2'b11;

    // Reset state, with requests pending while reset is held.
    repeat (2) @(posedge clk);
    #1; p_valid = 2'b11; p_we = 2'b11; p_mask = {8'hFF, 8'hFF};
    #1;
    check_eq("rst_req_ready", {p1_req_ready, p0_req_ready}, 2'b00);
    check_eq("rst_arr_we", arr_write_enable, 8'h00);
    check_eq("rst_rsp_valid", {p1_rsp_valid, p0_rsp_valid}, 2'b00);
    check_eq("rst_rsp_last", {p1_rsp_last, p0_rsp_last}, 2'b00);
    check_eq("rst_wr_ack", {p1_wr_ack, p0_wr_ack}, 2'b00);
    check_eq("rst_rsp_data", {p1_rsp_data, p0_rsp_data}, 16'h0000);
    sync();
    p_valid = 2'b00; rst = 1'b0;

    // Both ports stream two writes each: strict alternation starting at p0.
    base0 = ack_cnt[0]; base1 = ack_cnt[1];
    p_addr[0] = 9'h040; p_addr[1] = 9'h048; p_wdata = {8'h5A, 8'hC3};
    p_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("grant_order", {p1_req_ready, p0_req_ready}, (c % 2 == 0) ? 2'b01 : 2'b10);
      sync();
      p_addr[c % 2] = p_addr[c % 2] + 9'd1;
      p_wdata[c % 2] = 8'($urandom);
      if (c == 2) p_valid[0] = 1'b0;
      if (c == 3) p_valid = 2'b00;
    end
    repeat (2) @(negedge clk);
    check_eq("p0_ack_count", ack_cnt[0] - base0, 2);
    check_eq("p1_ack_count", ack_cnt[1] - base1, 2);

    // Single write: array drive in the accept cycle, ack one cycle later, then readback.
    sync();
    p_we[0] = 1'b1; p_addr[0] = 9'h012; p_mask[0] = 8'hFF; p_wdata[0] = 8'hA5; p_valid[0] = 1'b1;
    @(negedge clk);
    check_eq("wr_accept_ready", p0_req_ready, 1'b1);
    check_eq("wr_row_select", arr_row_select, 6'd2);
    check_eq("wr_col_select", arr_col_select, 3'd2);
    check_eq("wr_write_enable", arr_write_enable, 8'hFF);
    check_eq("wr_data_in", arr_data_in, 8'hA5);
    sync();
    p_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("wr_ack_pulse", p0_wr_ack, 1'b1);
    sync();
    send(0, 1'b0, 9'h012, 2'd0, 8'h00, 8'h00);
    @(negedge clk);
    check_eq("rd_not_early", p0_rsp_valid, 1'b0);
    @(negedge clk);
    check_eq("rd_valid_t2", p0_rsp_valid, 1'b1);
    check_eq("rd_data_t2", p0_rsp_data, 8'hA5);
    check_eq("rd_last_t2", p0_rsp_last, 1'b1);
    sync();

    // Wrapping 4-beat burst on p1, ready held high.
    burst = '{8'h11, 8'h22, 8'h33, 8'h44};
    send(0, 1'b1, 9'h1FF, 2'd0, 8'hFF, 8'h11);
    send(0, 1'b1, 9'h000, 2'd0, 8'hFF, 8'h22);
    send(0, 1'b1, 9'h001, 2'd0, 8'hFF, 8'h33);
    send(0, 1'b1, 9'h002, 2'd0, 8'hFF, 8'h44);
    send(1, 1'b0, 9'h1FF, 2'd3, 8'h00, 8'h00);
    @(negedge clk);
    check_eq("burst_not_early", p1_rsp_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("burst_valid", p1_rsp_valid, 1'b1);
      check_eq("burst_data", p1_rsp_data, burst[i]);
      check_eq("burst_last", p1_rsp_last, (i == 3) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    check_eq("burst_done", p1_rsp_valid, 1'b0);
    sync();

    // Same burst with a three-cycle consumer stall on the second beat.
    send(1, 1'b0, 9'h1FF, 2'd3, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check_eq("stall_beat0", p1_rsp_data, 8'h11);
    sync();
    rsp_ready[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_valid", p1_rsp_valid, 1'b1);
      check_eq("stall_data", p1_rsp_data, 8'h22);
      check_eq("stall_last", p1_rsp_last, 1'b0);
      check_eq("stall_arr_addr", arr_idx, 9'h001);
      sync();
    end
    rsp_ready[1] = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check_eq("resume_valid", p1_rsp_valid, 1'b1);
      check_eq("resume_data", p1_rsp_data, burst[i]);
    end
    sync();

    // Per-bit write mask, with read accepted the cycle after the last write.
    send(0, 1'b1, 9'h055, 2'd0, 8'hFF, 8'hFF);
    send(0, 1'b1, 9'h055, 2'd0, 8'h0F, 8'h00);
    send(0, 1'b0, 9'h055, 2'd0, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check_eq("mask_rd_data", p0_rsp_data, 8'hF0);
    sync();

    // Reset in the middle of a burst, then normal service afterwards.
    send(0, 1'b0, 9'h100, 2'd3, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_valid", p0_rsp_valid, 1'b1);
    @(posedge clk);
    #2; rst = 1'b1;
    #1;
    check_eq("midrst_rsp_valid", p0_rsp_valid, 1'b0);
    check_eq("midrst_rsp_last", p0_rsp_last, 1'b0);
    sync();
    rst = 1'b0;
    send(0, 1'b0, 9'h012, 2'd1, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    check_eq("postrst_data", p0_rsp_data, 8'hA5);
    check_eq("postrst_last0", p0_rsp_last, 1'b0);
    @(negedge clk);
    check_eq("postrst_last1", p0_rsp_last, 1'b1);
    sync();

    // Randomized traffic; requests hold until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = p_valid & {p1_req_ready, p0_req_ready};
      sync();
      for (int p = 0; p < 2; p++) begin
        if (!p_valid[p] || acc[p]) begin
          p_valid[p] = ($urandom_range(0, 2) != 0);
          p_we[p]    = ($urandom_range(0, 1) == 1);
          p_addr[p]  = ($urandom_range(0, 3) == 0) ? 9'(9'h1FC + 9'($urandom_range(0, 3)))
                                                   : 9'($urandom);
          p_len[p]   = 2'($urandom);
          p_mask[p]  = 8'($urandom);
          p_wdata[p] = 8'($urandom);
        end
      end
      rsp_ready = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
    end
    p_valid = 2'b00;
    rsp_ready = 2'b11;
    begin
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check_eq("drain_pending", q0.size() + q1.size(), 0);
    end
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Two-port arbiting controller that sequences all accesses to the SRAM cell array (row/column-group select, per-bit write enable). Each requester sends single-word masked writes or 1–4 beat incrementing read bursts over valid/ready. The block round-robins grants, drives the array address and write enables, and returns registered read data per port with backpressure.

Parameters:
ROWS, 64, array rows
COLS, 64, array columns
DATA_WIDTH, 8, word width; NUM_COL_GROUPS = COLS/DATA_WIDTH
ADDR_W, $clog2(ROWS)+$clog2(NUM_COL_GROUPS), word address width; addr = {row, col_group}

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  asynchronous, active-high reset
pN_req_valid  in  1  request valid, N=0,1
pN_req_ready  out  1  request accepted when valid&ready
pN_req_we  in  1  1=write, 0=read
pN_req_addr  in  ADDR_W  start word address
pN_req_len  in  2  read beats-1; ignored for writes
pN_req_wmask  in  DATA_WIDTH  per-bit write enable
pN_req_wdata  in  DATA_WIDTH  write data
pN_wr_ack  out  1  one-cycle pulse the cycle after write accept
pN_rsp_valid  out  1  read beat valid
pN_rsp_ready  in  1  read beat consumed when valid&ready
pN_rsp_data  out  DATA_WIDTH  read beat data
pN_rsp_last  out  1  final beat of burst
arr_row_select  out  $clog2(ROWS)  to array
arr_col_select  out  $clog2(NUM_COL_GROUPS)  to array
arr_write_enable  out  DATA_WIDTH  to array
arr_data_in  out  DATA_WIDTH  to array
arr_data_out  in  DATA_WIDTH  from array, combinational read of selected word

Behaviour:
- Reset (async, immediate): state IDLE; all rsp_valid/rsp_last/wr_ack 0; rsp_data 0; burst regs 0; last_grant=1 (port 0 wins first).
- States: IDLE, READ. arr_write_enable is 0 in every cycle except a write accept; req_ready is 0 outside IDLE and while rst high.
- IDLE arbitration: eligible = valid & (we | both rsp_valid low). One eligible -> granted. Both -> port != last_grant. req_ready high combinationally only for granted port. last_grant updates on accept.
- Write accept (cycle T): arr selects = req_addr, arr_write_enable = wmask, arr_data_in = wdata; cells update at end of T; wr_ack pulses at T+1; stay IDLE. Back-to-back writes every cycle allowed.
- Read accept (T): latch port, addr, beats = len+1; -> READ. In READ, arr selects = burst addr register.
- READ beat load: when rsp_valid==0 or rsp_ready==1, capture arr_data_out into rsp_data, set rsp_valid, addr = addr+1 mod ROWS*NUM_COL_GROUPS (wraps 0x1FF->0x000 at defaults), beats--. Last load sets rsp_last and returns to IDLE. First beat valid at T+2; 1 beat/cycle with rsp_ready held high.
- rsp_valid clears on valid&ready with no new load; rsp_data/rsp_last stable while valid&!ready.
- Array address stable during stall.
- Read-after-write: write at T visible to read accepted at T+1.
- In IDLE with no accept, arr selects follow granted (or port 0) address, write enable 0.

Optional Feature:
SRAM_ARB_PERF_EN: defined -> adds outputs p0_grant_cnt, p1_grant_cnt (16 bit each): count accepted requests per port, saturate at 0xFFFF, cleared by rst. Undefined -> ports and counters absent; behaviour otherwise identical.

Test Plan:
- p0 write addr 0x012 wdata 0xA5 mask 0xFF -> same cycle arr_row_select=2, arr_col_select=2, arr_write_enable=0xFF; p0_wr_ack at T+1; p0 read 0x012 len 0 -> p0_rsp_data=0xA5, rsp_last=1 at T+2.
- After reset both ports hold 4 write requests continuously -> grant order p0,p1,p0,p1, one accept per cycle, 2 wr_ack pulses each.
- Write 0x11,0x22,0x33,0x44 at 0x1FF,0x000,0x001,0x002; p1 read 0x1FF len 3 -> beats 0x11,0x22,0x33,0x44 on consecutive cycles, last only on 0x44.
- Same burst with p1_rsp_ready low 3 cycles after beat 2 -> rsp_data held 0x22, no beat lost or duplicated, arr address stable.
- Write 0xFF mask 0xFF, then 0x00 mask 0x0F to same addr -> read returns 0xF0.
- rst asserted mid-burst (beat 2 of 4) -> rsp_valid/last 0 immediately; after release, p0 read accepted and completes normally.
